nn_result_argmax: RTL and testbench

Serial argmax encoder at the output of the second matrix-multiply stage. When the layer-2 chain reports finished, the block captures the 10 class sums, scans them one per cycle with signed compare, and presents the winning class index over a valid/ready handshake to the seven-segment digit driver. It is the producer for the digit path that the display consumes; `digit` holds the last accepted result between inferences.

---
 rtl/nn_result_argmax.sv | 132 +++++++++++++
 tb/tb_nn_result_argmax.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_result_argmax.sv
// nn_result_argmax
// Serial argmax encoder for the layer-2 class sums. A rising edge on start
// snapshots all class sums. The block then walks them one per clock with a
// signed, strict greater-than compare. The winning class index and its sum
// are offered to the digit driver over a valid/ready handshake.
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   start      level from layer-2 "finished"; its rising edge triggers a scan
//   sums_flat  NUM_CLASSES signed sums, class c at [c*SUM_W +: SUM_W]
//   busy       high while scanning
//   out_valid  result available, held until accepted
//   out_ready  consumer accepts the result (only looked at while holding)
//   digit      winning class index; keeps the last result after acceptance
//   max_sum    winning sum value; keeps the last result after acceptance
//   overrun    sticky flag: a start edge arrived while a scan or result
//              was still in flight
module nn_result_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int SUM_W       = 32,
  parameter int IDX_W       = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [NUM_CLASSES*SUM_W-1:0] sums_flat,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             digit,
  output logic [SUM_W-1:0]             max_sum,
  output logic                         overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t           state;
  logic             start_q;
  logic [SUM_W-1:0] capture [NUM_CLASSES];
  logic [SUM_W-1:0] best_val;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] cnt;

  logic             start_edge;
  logic             handshake;
  logic             begin_scan;
  logic [SUM_W-1:0] cand;
  logic             cand_wins;
  logic [SUM_W-1:0] next_val;
  logic [IDX_W-1:0] next_idx;

  assign start_edge = start & ~start_q;
  assign handshake  = (state == HOLD) & out_valid & out_ready;

  // A new capture can begin from IDLE. It can also begin in the same cycle
  // that the held result is accepted, so back-to-back inferences lose no
  // cycle and raise no overrun.
  assign begin_scan = start_edge & ((state == IDLE) | handshake);

  // Strict signed compare: on a tie the earlier (lower) index is kept.
  assign cand      = capture[cnt];
  assign cand_wins = $signed(cand) > $signed(best_val);
  assign next_val  = cand_wins ? cand : best_val;
  assign next_idx  = cand_wins ? cnt  : best_idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      best_val  <= '0;
      best_idx  <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      digit     <= '0;
      max_sum   <= '0;
      overrun   <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        capture[c] <= '0;
      end
    end else begin
      start_q <= start;

      // Any edge that cannot start a scan is dropped and flagged.
      if (start_edge && !begin_scan) begin
        overrun <= 1'b1;
      end

      if (begin_scan) begin
        // Snapshot the sums so later changes upstream cannot disturb
        // the scan. Class 0 seeds the running best.
        for (int c = 0; c < NUM_CLASSES; c++) begin
          capture[c] <= sums_flat[c*SUM_W +: SUM_W];
        end
        best_val  <= sums_flat[SUM_W-1:0];
        best_idx  <= '0;
        cnt       <= IDX_W'(1);
        busy      <= 1'b1;
        out_valid <= 1'b0;
        state     <= SCAN;
      end else begin
        case (state)
          IDLE: begin
          end
          SCAN: begin
            best_val <= next_val;
            best_idx <= next_idx;
            cnt      <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              digit     <= next_idx;
              max_sum   <= next_val;
              out_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= HOLD;
            end
          end
          HOLD: begin
            if (handshake) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_result_argmax.sv
// Testbench for nn_result_argmax. Directed sum vectors are applied with
// hand-computed winners. Each issued scan pushes its expected digit/max_sum
// into a queue. A monitor pops and compares on every accepted result.
// Latency, flag and reset behaviour are checked inline by the stimulus.
module tb_nn_result_argmax;

  localparam int NUM_CLASSES = 10;
  localparam int SUM_W       = 32;
  localparam int IDX_W       = 4;

  logic                         clk;
  logic                         reset_n;
  logic                         start;
  logic [NUM_CLASSES*SUM_W-1:0] sums_flat;
  logic                         busy;
  logic                         out_valid;
  logic                         out_ready;
  logic [IDX_W-1:0]             digit;
  logic [SUM_W-1:0]             max_sum;
  logic                         overrun;

  typedef struct packed {
    logic [IDX_W-1:0] digit;
    logic [SUM_W-1:0] max_sum;
  } result_t;

  result_t expect_q [$];
  int      vectors     = 0;
  int      miscompares = 0;

  nn_result_argmax #(
    .NUM_CLASSES(NUM_CLASSES),
    .SUM_W      (SUM_W),
    .IDX_W      (IDX_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .sums_flat(sums_flat),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .digit    (digit),
    .max_sum  (max_sum),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the design wedges somewhere the bounded waits miss.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [NUM_CLASSES*SUM_W-1:0] pack_sums(input int v [NUM_CLASSES]);
    logic [NUM_CLASSES*SUM_W-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      r[c*SUM_W +: SUM_W] = SUM_W'(v[c]);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start, queue the expected result and measure edge-to-valid
  // latency. With scramble set, sums_flat is rewritten every cycle after
  // the capture edge.
  task automatic apply_stimulus(input string name, input int v [NUM_CLASSES],
                                input logic [IDX_W-1:0] exp_digit,
                                input logic [SUM_W-1:0] exp_max,
                                input bit scramble);
    int      n;
    result_t r;
    sums_flat = pack_sums(v);
    start     = 1'b1;
    r.digit   = exp_digit;
    r.max_sum = exp_max;
    expect_q.push_back(r);
    step();
    check_output({name, "_busy"}, 64'(busy), 64'd1);
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      if (scramble) begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
          sums_flat[c*SUM_W +: SUM_W] = SUM_W'(32'h7FFF_0000 + n * 16 + c);
        end
      end
      step();
      n++;
    end
    check_output({name, "_latency"}, 64'(n), 64'd9);
    check_output({name, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  // Monitor: every accepted result must match the oldest expectation.
  initial begin
    result_t r;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (expect_q.size() == 0) begin
          check_output("unexpected_result", 64'(digit), 64'hFFFF);
        end else begin
          r = expect_q.pop_front();
          check_output("mon_digit", 64'(digit), 64'(r.digit));
          check_output("mon_max_sum", 64'(max_sum), 64'(r.max_sum));
        end
      end
    end
  end

  initial begin
    int v [NUM_CLASSES];
    int stable;

    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    sums_flat = '0;
    #1;
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_valid", 64'(out_valid), 64'd0);
    check_output("rst_digit", 64'(digit), 64'd0);
    check_output("rst_max_sum", 64'(max_sum), 64'd0);
    check_output("rst_overrun", 64'(overrun), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    $display("[TB] tie case, lowest index wins");
    v = '{5, -3, 12, 7, 0, 12, -100, 1, 2, 3};
    apply_stimulus("tie", v, 4'd2, 32'd12, 1'b0);
    check_output("tie_overrun", 64'(overrun), 64'd0);
    step();
    check_output("tie_one_cycle_valid", 64'(out_valid), 64'd0);
    step();

    $display("[TB] all negative sums");
    v = '{-50, -9, -20, -30, -40, -60, -70, -80, -90, -9};
    apply_stimulus("neg", v, 4'd1, 32'hFFFF_FFF7, 1'b0);
    step();
    step();

    $display("[TB] mixed sign, signed compare");
    v = '{3, -1, 0, 0, 0, 0, 0, 0, 0, 0};
    apply_stimulus("sign", v, 4'd0, 32'd3, 1'b0);
    step();
    step();

    $display("[TB] sums change during scan");
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 9};
    apply_stimulus("capture", v, 4'd9, 32'd9, 1'b1);
    step();
    step();

    $display("[TB] back-pressure and overrun");
    out_ready = 1'b0;
    v = '{0, 0, 0, 0, 40, 0, 0, 0, 0, 0};
    apply_stimulus("hold", v, 4'd4, 32'd40, 1'b0);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) start = 1'b1;
      if (i == 6) start = 1'b0;
      step();
      if (out_valid && digit == 4'd4 && max_sum == 32'd40) stable++;
    end
    check_output("hold_stable_cycles", 64'(stable), 64'd20);
    check_output("hold_overrun", 64'(overrun), 64'd1);
    out_ready = 1'b1;
    step();
    check_output("hold_valid_drop", 64'(out_valid), 64'd0);
    check_output("hold_digit_kept", 64'(digit), 64'd4);
    check_output("hold_max_kept", 64'(max_sum), 64'd40);
    step();

    $display("[TB] reset in the middle of a scan");
    v = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 950};
    sums_flat = pack_sums(v);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_busy", 64'(busy), 64'd0);
    check_output("mid_rst_valid", 64'(out_valid), 64'd0);
    check_output("mid_rst_digit", 64'(digit), 64'd0);
    check_output("mid_rst_max_sum", 64'(max_sum), 64'd0);
    check_output("mid_rst_overrun", 64'(overrun), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    step();
    check_output("post_rst_valid", 64'(out_valid), 64'd0);
    check_output("post_rst_busy", 64'(busy), 64'd0);
    v = '{1, 2, 3, 4, 5, 6, 7, 1000, 8, 9};
    apply_stimulus("post_rst", v, 4'd7, 32'd1000, 1'b0);
    step();
    step();

    $display("[TB] handshake coincident with new start");
    out_ready = 1'b0;
    v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    apply_stimulus("coinc_first", v, 4'd0, 32'd0, 1'b0);
    step();
    begin
      result_t r;
      int n;
      v = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 8};
      sums_flat = pack_sums(v);
      r.digit   = 4'd9;
      r.max_sum = 32'd8;
      expect_q.push_back(r);
      start     = 1'b1;
      out_ready = 1'b1;
      step();
      check_output("coinc_valid_low", 64'(out_valid), 64'd0);
      check_output("coinc_busy", 64'(busy), 64'd1);
      check_output("coinc_overrun", 64'(overrun), 64'd0);
      start = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
        step();
        n++;
      end
      check_output("coinc_latency", 64'(n), 64'd9);
    end
    step();
    step();

    check_output("queue_drained", 64'(expect_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
